// File: rtl/gb_pkg.sv
// Shared Game Boy definitions: timer register map, TAC tap-select encoding,
// overflow-delay FSM states and the tap multiplexer helper.
package gb_pkg;

  // Timer register addresses on the CPU bus.
  localparam logic [15:0] TIMER_DIV_ADDR  = 16'hFF04;
  localparam logic [15:0] TIMER_TIMA_ADDR = 16'hFF05;
  localparam logic [15:0] TIMER_TMA_ADDR  = 16'hFF06;
  localparam logic [15:0] TIMER_TAC_ADDR  = 16'hFF07;

  // TAC[1:0] selects which sys_cnt bit clocks TIMA.
  typedef enum logic [1:0] {
    TacTap9 = 2'b00,
    TacTap3 = 2'b01,
    TacTap5 = 2'b10,
    TacTap7 = 2'b11
  } tac_tap_e;

  // Overflow delay FSM: four tick-paced delay slots, then one reload cycle.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDelay0 = 3'd1,
    StDelay1 = 3'd2,
    StDelay2 = 3'd3,
    StDelay3 = 3'd4,
    StReload = 3'd5
  } ovf_state_e;

  // Return the sys_cnt bit chosen by the TAC tap select.
  function automatic logic tap_bit(input logic [15:0] cnt, input logic [1:0] sel);
    logic b;
    b = 1'b0;
    unique case (tac_tap_e'(sel))
      TacTap9: b = cnt[9];
      TacTap3: b = cnt[3];
      TacTap5: b = cnt[5];
      TacTap7: b = cnt[7];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gb_timer_ovf.sv
// TIMA overflow delay/cancel FSM, used only when TIMER_OVF_DELAY_EN is defined.
// After an overflow TIMA stays 0x00 for four ticks; the edge leaving the last
// delay slot reloads TIMA and the following single Clk raises the interrupt.
// A CPU write to TIMA while a delay slot is active abandons reload and irq.
module gb_timer_ovf
  import gb_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_ovf,
  input  logic i_cancel,
  output logic o_reload,
  output logic o_irq
);

  ovf_state_e r_state;
  ovf_state_e w_state_nxt;

  // State register with synchronous reset; reset drops any pending reload.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; o_reload marks the edge that copies TMA into TIMA.
  always_comb begin
    w_state_nxt = r_state;
    o_reload    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_ovf) w_state_nxt = StDelay0;
      end
      StDelay0: begin
        if (i_cancel)    w_state_nxt = StIdle;
        else if (i_tick) w_state_nxt = StDelay1;
      end
      StDelay1: begin
        if (i_cancel)    w_state_nxt = StIdle;
        else if (i_tick) w_state_nxt = StDelay2;
      end
      StDelay2: begin
        if (i_cancel)    w_state_nxt = StIdle;
        else if (i_tick) w_state_nxt = StDelay3;
      end
      StDelay3: begin
        if (i_cancel) begin
          w_state_nxt = StIdle;
        end else if (i_tick) begin
          w_state_nxt = StReload;
          o_reload    = 1'b1;
        end
      end
      StReload: begin
        // Reload cycle lasts exactly one Clk so the irq is a single pulse.
        w_state_nxt = i_ovf ? StDelay0 : StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_irq = (r_state == StReload);

endmodule

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer.
// Optional feature macro: TIMER_OVF_DELAY_EN. When defined, a TIMA overflow
// holds TIMA at 0x00 for four ticks before reloading from TMA and raising the
// interrupt, and a TIMA write inside that window cancels both. When undefined,
// reload and interrupt happen on the overflow edge itself.
module gb_timer
  import gb_pkg::*;
(
  input  logic        Clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        mem_wren,
  output logic [7:0]  timer_data,
  output logic        timer_sel,
  output logic        timer_irq
);

  logic [15:0] r_sys_cnt;
  logic [7:0]  r_tima;
  logic [7:0]  r_tma;
  logic [2:0]  r_tac;
  logic        r_gate;

  logic        w_wr_div;
  logic        w_wr_tima;
  logic        w_wr_tma;
  logic        w_wr_tac;
  logic [15:0] w_sys_cnt_nxt;
  logic [2:0]  w_tac_nxt;
  logic [7:0]  w_tma_nxt;
  logic [7:0]  w_tima_nxt;
  logic [7:0]  w_reload_val;
  logic        w_gate_nxt;
  logic        w_inc;
  logic        w_ovf;
  logic        w_reload;
  logic        w_irq;

  assign w_wr_div  = mem_wren && (mem_addr == TIMER_DIV_ADDR);
  assign w_wr_tima = mem_wren && (mem_addr == TIMER_TIMA_ADDR);
  assign w_wr_tma  = mem_wren && (mem_addr == TIMER_TMA_ADDR);
  assign w_wr_tac  = mem_wren && (mem_addr == TIMER_TAC_ADDR);

  // Next values of counter and control registers, including CPU writes.
  always_comb begin
    w_sys_cnt_nxt = r_sys_cnt;
    if (w_wr_div) begin
      w_sys_cnt_nxt = 16'h0000;
    end else if (tick) begin
      w_sys_cnt_nxt = r_sys_cnt + 16'd1;
    end
    w_tac_nxt    = w_wr_tac ? cpu_data_out[2:0] : r_tac;
    w_tma_nxt    = w_wr_tma ? cpu_data_out : r_tma;
    // A TMA write landing on the reload edge is what TIMA receives.
    w_reload_val = w_tma_nxt;
  end

  // The gate is evaluated on the post-edge state so that counter steps, DIV
  // resets and TAC rewrites all show up as the same kind of falling edge.
  // Edges on Clk cycles without a tick are absorbed and not counted.
  assign w_gate_nxt = w_tac_nxt[2] & tap_bit(w_sys_cnt_nxt, w_tac_nxt[1:0]);
  assign w_inc      = tick & r_gate & ~w_gate_nxt;
  assign w_ovf      = w_inc & ~w_wr_tima & (r_tima == 8'hFF);

`ifdef TIMER_OVF_DELAY_EN
  gb_timer_ovf u_ovf (
    .i_clk    (Clk),
    .i_reset  (reset),
    .i_tick   (tick),
    .i_ovf    (w_ovf),
    .i_cancel (w_wr_tima),
    .o_reload (w_reload),
    .o_irq    (w_irq)
  );
`else
  logic r_irq;

  assign w_reload = w_ovf;

  // Interrupt pulse registered on the overflow edge, high for one Clk.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_ovf;
    end
  end

  assign w_irq = r_irq;
`endif

  // TIMA next value: CPU write beats reload, reload beats increment.
  always_comb begin
    w_tima_nxt = r_tima;
    if (w_wr_tima) begin
      w_tima_nxt = cpu_data_out;
    end else if (w_reload) begin
      w_tima_nxt = w_reload_val;
    end else if (w_inc) begin
      w_tima_nxt = r_tima + 8'd1;
    end
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_sys_cnt <= 16'h0000;
      r_tima    <= 8'h00;
      r_tma     <= 8'h00;
      r_tac     <= 3'b000;
      r_gate    <= 1'b0;
    end else begin
      r_sys_cnt <= w_sys_cnt_nxt;
      r_tima    <= w_tima_nxt;
      r_tma     <= w_tma_nxt;
      r_tac     <= w_tac_nxt;
      r_gate    <= w_gate_nxt;
    end
  end

  assign timer_irq = w_irq;

  // Combinational read mux for the addressed timer register.
  always_comb begin
    timer_sel  = (mem_addr[15:2] == TIMER_DIV_ADDR[15:2]);
    timer_data = 8'hFF;
    if (timer_sel) begin
      unique case (mem_addr[1:0])
        2'b00:   timer_data = r_sys_cnt[15:8];
        2'b01:   timer_data = r_tima;
        2'b10:   timer_data = r_tma;
        2'b11:   timer_data = {5'b11111, r_tac};
        default: timer_data = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer. Stimulus pushes expected read data, select
// and irq values into queues; a negedge monitor pops and compares whenever a
// read is presented. Expectations follow TIMER_OVF_DELAY_EN when defined.
module tb_gb_timer;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        mem_wren = 1'b0;
  logic [7:0]  timer_data;
  logic        timer_sel;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail = 0;
  int irq_seen = 0;
  int exp_irq_total = 0;
  logic rd_valid = 1'b0;

  bit         q_kind[$];
  logic [7:0] q_data[$];
  logic       q_sel[$];
  logic       q_irq[$];
  int         q_cnt[$];
  string      q_name[$];

  gb_timer dut (
    .Clk          (Clk),
    .reset        (reset),
    .tick         (tick),
    .mem_addr     (mem_addr),
    .cpu_data_out (cpu_data_out),
    .mem_wren     (mem_wren),
    .timer_data   (timer_data),
    .timer_sel    (timer_sel),
    .timer_irq    (timer_irq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: counts irq cycles and checks each presented read.
  initial begin
    bit k;
    logic [7:0] d;
    logic s;
    logic i;
    int c;
    string nm;
    forever begin
      @(negedge Clk);
      if (timer_irq === 1'b1) irq_seen++;
      if (rd_valid) begin
        if (q_kind.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: read presented with no expectation");
        end else begin
          k  = q_kind.pop_front();
          d  = q_data.pop_front();
          s  = q_sel.pop_front();
          i  = q_irq.pop_front();
          c  = q_cnt.pop_front();
          nm = q_name.pop_front();
          if (k == 1'b0) begin
            check({nm, ".data"}, int'(timer_data), int'(d));
            check({nm, ".sel"}, int'(timer_sel), int'(s));
            check({nm, ".irq"}, int'(timer_irq), int'(i));
          end else begin
            check({nm, ".irq_count"}, irq_seen, c);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic tk, input logic wr, input logic [15:0] a, input logic [7:0] d);
    tick = tk;
    mem_wren = wr;
    mem_addr = a;
    cpu_data_out = d;
    @(posedge Clk);
    #1;
    tick = 1'b0;
    mem_wren = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic tk);
    step(tk, 1'b1, a, d);
  endtask

  task automatic rd(input logic tk, input logic [15:0] a, input logic [7:0] ed, input logic ei,
                    input string nm);
    q_kind.push_back(1'b0);
    q_data.push_back(ed);
    q_sel.push_back((a >= 16'hFF04) && (a <= 16'hFF07));
    q_irq.push_back(ei);
    q_cnt.push_back(0);
    q_name.push_back(nm);
    rd_valid = 1'b1;
    step(tk, 1'b0, a, 8'h00);
    rd_valid = 1'b0;
  endtask

  task automatic irq_count(input string nm);
    q_kind.push_back(1'b1);
    q_data.push_back(8'h00);
    q_sel.push_back(1'b0);
    q_irq.push_back(1'b0);
    q_cnt.push_back(exp_irq_total);
    q_name.push_back(nm);
    rd_valid = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 8'h00);
    rd_valid = 1'b0;
  endtask

  task automatic do_reset(input logic tk);
    reset = 1'b1;
    tick = tk;
    @(posedge Clk);
    #1;
    reset = 1'b0;
    tick = 1'b0;
  endtask

  // TIMA=0xFF, tap bit 3 high: the next tick overflows TIMA.
  task automatic to_overflow();
    do_reset(1'b0);
    wr(A_TAC, 8'h05, 1'b0);
    wr(A_TIMA, 8'hFF, 1'b0);
    wr(A_TMA, 8'h80, 1'b0);
    run(15);
  endtask

  initial begin
    // Reset state and free-running DIV.
    do_reset(1'b0);
    rd(1'b0, A_DIV, 8'h00, 1'b0, "rst_div");
    rd(1'b0, A_TIMA, 8'h00, 1'b0, "rst_tima");
    rd(1'b0, A_TMA, 8'h00, 1'b0, "rst_tma");
    rd(1'b0, A_TAC, 8'hF8, 1'b0, "rst_tac");
    rd(1'b0, 16'hFF03, 8'hFF, 1'b0, "unmapped_ff03");
    rd(1'b0, 16'hFF08, 8'hFF, 1'b0, "unmapped_ff08");
    run(255);
    rd(1'b0, A_DIV, 8'h00, 1'b0, "div_255");
    run(1);
    rd(1'b0, A_DIV, 8'h01, 1'b0, "div_256");
    rd(1'b0, A_TIMA, 8'h00, 1'b0, "tima_disabled");
    irq_count("no_irq_256");

    // Overflow and reload from TMA.
    do_reset(1'b0);
    wr(A_TAC, 8'h05, 1'b0);
    wr(A_TIMA, 8'hFE, 1'b0);
    wr(A_TMA, 8'h80, 1'b0);
    run(15);
    rd(1'b0, A_TIMA, 8'hFE, 1'b0, "wrap_pre_edge");
    run(1);
    rd(1'b0, A_TIMA, 8'hFF, 1'b0, "wrap_first_edge");
    run(15);
    rd(1'b1, A_TIMA, 8'hFF, 1'b0, "wrap_ovf_cycle");
`ifdef TIMER_OVF_DELAY_EN
    repeat (4) rd(1'b1, A_TIMA, 8'h00, 1'b0, "wrap_delay");
`endif
    exp_irq_total++;
    rd(1'b1, A_TIMA, 8'h80, 1'b1, "wrap_reload");
    rd(1'b1, A_TIMA, 8'h80, 1'b0, "wrap_irq_end");
    irq_count("wrap_irq");

    // CPU write to TIMA beats a same-cycle increment.
    do_reset(1'b0);
    wr(A_TAC, 8'h05, 1'b0);
    wr(A_TIMA, 8'h10, 1'b0);
    run(15);
    wr(A_TIMA, 8'h33, 1'b1);
    rd(1'b0, A_TIMA, 8'h33, 1'b0, "wr_beats_inc");
    run(16);
    rd(1'b0, A_TIMA, 8'h34, 1'b0, "inc_after_wr");

    // TMA written on the reload cycle is the value loaded.
    to_overflow();
`ifdef TIMER_OVF_DELAY_EN
    rd(1'b1, A_TIMA, 8'hFF, 1'b0, "tma_ovf_cycle");
    repeat (3) rd(1'b1, A_TIMA, 8'h00, 1'b0, "tma_delay");
`endif
    wr(A_TMA, 8'h55, 1'b1);
    exp_irq_total++;
    rd(1'b1, A_TIMA, 8'h55, 1'b1, "tma_new_reload");
    rd(1'b0, A_TMA, 8'h55, 1'b0, "tma_latched");

`ifdef TIMER_OVF_DELAY_EN
    // TIMA write inside the delay window cancels reload and irq.
    to_overflow();
    rd(1'b1, A_TIMA, 8'hFF, 1'b0, "cancel_ovf_cycle");
    rd(1'b1, A_TIMA, 8'h00, 1'b0, "cancel_delay0");
    wr(A_TIMA, 8'h33, 1'b1);
    repeat (6) rd(1'b1, A_TIMA, 8'h33, 1'b0, "cancel_hold");
    irq_count("cancel_no_irq");
`endif

    // DIV write clears sys_cnt and its gate falling edge bumps TIMA.
    do_reset(1'b0);
    wr(A_TAC, 8'h05, 1'b0);
    run(8);
    rd(1'b0, A_TIMA, 8'h00, 1'b0, "div_wr_pre");
    wr(A_DIV, 8'hAB, 1'b1);
    rd(1'b0, A_DIV, 8'h00, 1'b0, "div_wr_div");
    rd(1'b0, A_TIMA, 8'h01, 1'b0, "div_wr_tima");
    run(15);
    rd(1'b0, A_TIMA, 8'h01, 1'b0, "div_wr_cnt15");
    run(1);
    rd(1'b0, A_TIMA, 8'h02, 1'b0, "div_wr_cnt16");

    // Disabling TAC while the tap is high bumps TIMA.
    do_reset(1'b0);
    wr(A_TAC, 8'h04, 1'b0);
    run(512);
    rd(1'b0, A_TIMA, 8'h00, 1'b0, "tac_off_pre");
    wr(A_TAC, 8'h00, 1'b1);
    rd(1'b0, A_TIMA, 8'h01, 1'b0, "tac_off_tima");
    rd(1'b0, A_TAC, 8'hF8, 1'b0, "tac_off_tac");
    rd(1'b0, A_DIV, 8'h02, 1'b0, "tac_off_div");

    // Taps 5 and 7.
    do_reset(1'b0);
    wr(A_TAC, 8'h06, 1'b0);
    run(63);
    rd(1'b0, A_TIMA, 8'h00, 1'b0, "tap5_63");
    run(1);
    rd(1'b0, A_TIMA, 8'h01, 1'b0, "tap5_64");
    wr(A_TAC, 8'h07, 1'b0);
    run(191);
    rd(1'b0, A_TIMA, 8'h01, 1'b0, "tap7_255");
    run(1);
    rd(1'b0, A_TIMA, 8'h02, 1'b0, "tap7_256");

    // Reset shortly after overflow: everything clears, no later irq.
    to_overflow();
    rd(1'b1, A_TIMA, 8'hFF, 1'b0, "rstdly_ovf_cycle");
`ifdef TIMER_OVF_DELAY_EN
    rd(1'b1, A_TIMA, 8'h00, 1'b0, "rstdly_delay0");
`else
    exp_irq_total++;
    rd(1'b1, A_TIMA, 8'h80, 1'b1, "rstdly_reload");
`endif
    do_reset(1'b1);
    repeat (16) rd(1'b1, A_TIMA, 8'h00, 1'b0, "rstdly_post");
    rd(1'b0, A_TMA, 8'h00, 1'b0, "rstdly_tma");
    rd(1'b0, A_TAC, 8'hF8, 1'b0, "rstdly_tac");
    rd(1'b0, A_DIV, 8'h00, 1'b0, "rstdly_div");
    irq_count("rstdly_irq");

    step(1'b0, 1'b0, 16'h0000, 8'h00);
    step(1'b0, 1'b0, 16'h0000, 8'h00);
    check("scoreboard_drained", q_kind.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_timer.md
GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 SHALL have ports: Clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: tick  input  1  T-cycle enable; counter logic advances only when tick=1.
REQ-004 SHALL have ports: mem_addr  input  16  CPU bus address.
REQ-005 SHALL have ports: cpu_data_out  input  8  CPU write data.
REQ-006 SHALL have ports: mem_wren  input  1  CPU write strobe, one Clk cycle per write.
REQ-007 SHALL have ports: timer_data  output  8  read data for the addressed register, combinational.
REQ-008 SHALL have ports: timer_sel  output  1  high when mem_addr is in 0xFF04..0xFF07.
REQ-009 SHALL have ports: timer_irq  output  1  one-Clk pulse requesting IF bit 2.

Function
REQ-010 SHALL keep a 16-bit internal counter sys_cnt, +1 per tick, wrapping 0xFFFF->0x0000; DIV (0xFF04) reads sys_cnt[15:8].
REQ-011 SHALL hold TIMA (0xFF05), TMA (0xFF06) and TAC[2:0] (0xFF07); TAC reads {5'b11111, TAC[2:0]}.
REQ-012 SHALL drive timer_data=0xFF when timer_sel=0.
REQ-013 SHALL select the tap bit by TAC[1:0]: 00->sys_cnt[9], 01->sys_cnt[3], 10->sys_cnt[5], 11->sys_cnt[7].
REQ-014 SHALL compute the gate as tap AND TAC[2], register it each Clk, and increment TIMA on every 1->0 transition of the gate.
REQ-015 SHALL reset sys_cnt to 0 on any write to 0xFF04, regardless of data; the resulting gate falling edge SHALL increment TIMA.
REQ-016 SHALL apply a TAC write that lowers the gate (disable or tap change) as a falling edge that increments TIMA.
REQ-017 SHALL, on TIMA overflow 0xFF->0x00, perform a reload (TIMA<=TMA) and pulse timer_irq for exactly one Clk; the timing is set by REQ-023/REQ-024.
REQ-018 SHALL give a CPU write to TIMA priority over a same-cycle increment.
REQ-019 SHALL, when a TMA write coincides with the reload cycle, load TIMA with the new TMA value.
REQ-020 SHALL ignore writes when tick=0 for counting purposes, but still latch the written register value.

Reset
REQ-021 SHALL on reset=1 at a Clk edge clear sys_cnt, TIMA, TMA, TAC, the gate register and the overflow-delay state, and drive timer_irq=0.
REQ-022 SHALL abandon any pending reload when reset arrives mid-delay, with no irq pulse afterwards.

Configuration
REQ-023 With TIMER_OVF_DELAY_EN defined: on overflow TIMA SHALL read 0x00 for 4 ticks, then reload and pulse irq. A CPU write to TIMA inside the window SHALL cancel both the reload and the irq.
REQ-024 Without TIMER_OVF_DELAY_EN: reload and irq pulse SHALL occur on the same Clk edge as the overflow; no cancellation window exists.

Structure
REQ-025 SHALL place register address localparams (TIMER_DIV_ADDR..TIMER_TAC_ADDR) and the TAC tap-select encoding in shared package gb_pkg.
REQ-026 SHALL be flat apart from one optional sub-module gb_timer_ovf (overflow delay/cancel FSM: IDLE -> DELAY[0..3] -> RELOAD -> IDLE).

Verification
REQ-027 Reset, then tick=1 for 256 ticks -> DIV reads 0x01, TIMA 0x00, timer_irq never high.
REQ-028 TAC=0x05, TIMA=0xFE, TMA=0x80, then 32 ticks -> TIMA wraps. With macro: TIMA reads 0x00 for 4 ticks, then 0x80 with one irq pulse. Without macro: 0x80 and irq pulse immediately.
REQ-029 Macro on; overflow as in REQ-028; write TIMA=0x33 on the 2nd delay tick -> TIMA stays 0x33, no irq.
REQ-030 TAC=0x05, run until sys_cnt[3]=1, write DIV=0xAB -> sys_cnt=0, DIV reads 0x00, TIMA +1.
REQ-031 TAC=0x04, sys_cnt[9]=1, write TAC=0x00 -> TIMA +1; TAC reads 0xF8.
REQ-032 Macro on; reset asserted during the overflow delay -> all registers 0, no irq pulse in the following 16 cycles.
